// File: rtl/disc_writer_pkg.sv
// Shared definitions for the disc write path: command codes, FSM encoding and
// the per-command launch descriptor.
package disc_writer_pkg;

  localparam logic [7:0] CMD_GAP     = 8'h80;
  localparam logic [7:0] CMD_WAITIDX = 8'hFE;
  localparam logic [7:0] CMD_END     = 8'hFF;
  localparam logic [7:0] GAP_LEN_M1  = 8'd127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_LEAD,
    S_EXEC,
    S_PULSE,
    S_WAIT_IDX,
    S_TRAIL
  } state_t;

  // Where the FSM goes, and with what counter/data-line value, on the first
  // cycle of a freshly loaded command.
  typedef struct packed {
    state_t     st;
    logic [7:0] cnt;
    logic       wrdata;
  } launch_t;

  function automatic logic is_interval(input logic [7:0] cmd);
    return ~cmd[7];
  endfunction

endpackage

// File: rtl/index_edge_sync.sv
// Two-flop synchroniser for an asynchronous active-low strobe plus a
// one-cycle falling-edge pulse; idle level is high.
module index_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic fall
);

  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= sig;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign fall = prev & ~s2;

endmodule

// File: rtl/disc_writer.sv
// Streams encoded interval bytes from SRAM and turns them into active-low
// flux-transition pulses on FD_WRDATA, framed by FD_WRGATE.
module disc_writer
  import disc_writer_pkg::*;
#(
  parameter int PULSE_WIDTH = 4,
  parameter int GATE_LEAD   = 8,
  parameter int GATE_TRAIL  = 8
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic       ABORT,
  input  logic       FD_WRPROT_IN,
  input  logic       FD_INDEX_IN,
  output logic       MEM_RD_REQ,
  input  logic       MEM_RD_ACK,
  input  logic [7:0] MEM_DATA,
  output logic       FD_WRDATA,
  output logic       FD_WRGATE,
  output logic       BUSY,
  output logic       DONE,
  output logic       UNDERRUN,
  output logic       WRPROT_ERR
);

  localparam logic [7:0] PW_M1    = 8'(PULSE_WIDTH - 1);
  localparam logic [7:0] LEAD_M1  = 8'(GATE_LEAD - 1);
  localparam logic [7:0] TRAIL_M1 = 8'(GATE_TRAIL - 1);

  state_t     state, state_n;
  logic [7:0] cur, cur_n;
  logic [7:0] cnt, cnt_n;
  logic       pf_valid, pf_valid_n;
  logic [7:0] pf_data, pf_data_n;
  logic       end_fetched, end_n;
  logic       gate, gate_n;
  logic       wdata, wdata_n;
  logic       done, done_n;
  logic       underrun, und_n;
  logic       wp_err, wp_n;
  logic       complete;
  logic       ack_ok;
  logic       idx_fall;
  launch_t    l_cur, l_pf;

  index_edge_sync u_idx (
    .clk  (CLOCK),
    .rst  (RESET),
    .sig  (FD_INDEX_IN),
    .fall (idx_fall)
  );

  // A zero interval skips the high phase and drops FD_WRDATA on the very
  // first cycle, so consecutive 0x00 commands repeat every PULSE_WIDTH.
  function automatic launch_t launch(input logic [7:0] cmd);
    launch_t l;
    l.st     = S_EXEC;
    l.cnt    = 8'd0;
    l.wrdata = 1'b1;
    if (cmd == CMD_END) begin
      l.st  = S_TRAIL;
      l.cnt = TRAIL_M1;
    end else if (cmd == CMD_WAITIDX) begin
      l.st = S_WAIT_IDX;
    end else if (cmd == CMD_GAP) begin
      l.cnt = GAP_LEN_M1;
    end else if (is_interval(cmd)) begin
      if (cmd == 8'd0) begin
        l.st     = S_PULSE;
        l.cnt    = PW_M1;
        l.wrdata = 1'b0;
      end else begin
        l.cnt = cmd - 8'd1;
      end
    end
    return l;
  endfunction

  assign l_cur = launch(cur);
  assign l_pf  = launch(pf_data);

  assign MEM_RD_REQ = (state == S_PRIME) ||
                      ((state inside {S_LEAD, S_EXEC, S_PULSE, S_WAIT_IDX}) &&
                       !pf_valid && !end_fetched);
  assign ack_ok     = MEM_RD_ACK && MEM_RD_REQ;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= S_IDLE;
      cur         <= 8'd0;
      cnt         <= 8'd0;
      pf_valid    <= 1'b0;
      pf_data     <= 8'd0;
      end_fetched <= 1'b0;
      gate        <= 1'b1;
      wdata       <= 1'b1;
      done        <= 1'b0;
      underrun    <= 1'b0;
      wp_err      <= 1'b0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      cnt         <= cnt_n;
      pf_valid    <= pf_valid_n;
      pf_data     <= pf_data_n;
      end_fetched <= end_n;
      gate        <= gate_n;
      wdata       <= wdata_n;
      done        <= done_n;
      underrun    <= und_n;
      wp_err      <= wp_n;
    end
  end

  always_comb begin
    state_n    = state;
    cur_n      = cur;
    cnt_n      = cnt;
    pf_valid_n = pf_valid;
    pf_data_n  = pf_data;
    end_n      = end_fetched;
    gate_n     = gate;
    wdata_n    = wdata;
    done_n     = done;
    und_n      = underrun;
    wp_n       = wp_err;
    complete   = 1'b0;

    if (ack_ok && state != S_PRIME) begin
      pf_valid_n = 1'b1;
      pf_data_n  = MEM_DATA;
    end
    if (ack_ok && MEM_DATA == CMD_END) end_n = 1'b1;

    case (state)
      S_IDLE: begin
        if (START) begin
          if (!FD_WRPROT_IN) begin
            wp_n = 1'b1;
          end else begin
            done_n     = 1'b0;
            und_n      = 1'b0;
            wp_n       = 1'b0;
            end_n      = 1'b0;
            pf_valid_n = 1'b0;
            state_n    = S_PRIME;
          end
        end
      end
      S_PRIME: begin
        if (ack_ok) begin
          cur_n   = MEM_DATA;
          cnt_n   = LEAD_M1;
          gate_n  = 1'b0;
          state_n = S_LEAD;
        end
      end
      S_LEAD: begin
        if (cnt == 8'd0) begin
          state_n = l_cur.st;
          cnt_n   = l_cur.cnt;
          wdata_n = l_cur.wrdata;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_EXEC: begin
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else if (is_interval(cur)) begin
          state_n = S_PULSE;
          cnt_n   = PW_M1;
          wdata_n = 1'b0;
        end else begin
          complete = 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt == 8'd0) begin
          wdata_n  = 1'b1;
          complete = 1'b1;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_WAIT_IDX: begin
        if (idx_fall) complete = 1'b1;
      end
      S_TRAIL: begin
        if (cnt == 8'd0) begin
          gate_n  = 1'b1;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Hand over to the prefetched byte in the completing cycle; with nothing
    // prefetched the write is abandoned and any same-cycle ack is dropped.
    if (complete) begin
      if (pf_valid) begin
        cur_n      = pf_data;
        pf_valid_n = 1'b0;
        state_n    = l_pf.st;
        cnt_n      = l_pf.cnt;
        wdata_n    = l_pf.wrdata;
      end else begin
        state_n    = S_IDLE;
        gate_n     = 1'b1;
        wdata_n    = 1'b1;
        und_n      = 1'b1;
        pf_valid_n = 1'b0;
      end
    end

    if (ABORT) begin
      state_n    = S_IDLE;
      gate_n     = 1'b1;
      wdata_n    = 1'b1;
      pf_valid_n = 1'b0;
      end_n      = end_fetched;
      done_n     = done;
      und_n      = underrun;
      wp_n       = wp_err;
    end
  end

  assign FD_WRDATA  = wdata;
  assign FD_WRGATE  = gate;
  assign BUSY       = (state != S_IDLE);
  assign DONE       = done;
  assign UNDERRUN   = underrun;
  assign WRPROT_ERR = wp_err;

endmodule

// File: tb/tb_disc_writer.sv
// Directed bench for disc_writer: control-pin vector table, then hand-timed
// streams against a small SRAM model with configurable ack latency.
module tb_disc_writer;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic       FD_WRPROT_IN = 1'b1;
  logic       FD_INDEX_IN = 1'b1;
  logic       MEM_RD_REQ;
  logic       MEM_RD_ACK = 1'b0;
  logic [7:0] MEM_DATA = 8'h00;
  logic       FD_WRDATA, FD_WRGATE, BUSY, DONE, UNDERRUN, WRPROT_ERR;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [4];
  int ack_count = 0;
  int base = 0;
  int mem_delay = 1000;
  int wcnt = 0;

  typedef struct {
    logic start, abort, wp;
    logic busy, err, gate, req;
  } vec_t;
  vec_t tbl [8];

  disc_writer #(.PULSE_WIDTH(4), .GATE_LEAD(8), .GATE_TRAIL(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .FD_WRPROT_IN(FD_WRPROT_IN), .FD_INDEX_IN(FD_INDEX_IN),
    .MEM_RD_REQ(MEM_RD_REQ), .MEM_RD_ACK(MEM_RD_ACK), .MEM_DATA(MEM_DATA),
    .FD_WRDATA(FD_WRDATA), .FD_WRGATE(FD_WRGATE), .BUSY(BUSY), .DONE(DONE),
    .UNDERRUN(UNDERRUN), .WRPROT_ERR(WRPROT_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  // SRAM model: ack one cycle after REQ has been seen for mem_delay cycles.
  initial begin
    int a;
    forever begin
      @(negedge CLOCK);
      if (MEM_RD_ACK) begin
        MEM_RD_ACK = 1'b0;
        ack_count++;
        wcnt = 0;
      end else if (MEM_RD_REQ) begin
        if (wcnt >= mem_delay) begin
          a = ack_count - base;
          MEM_DATA = (a >= 0 && a < 4) ? mem[a[1:0]] : 8'hFF;
          MEM_RD_ACK = 1'b1;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk1(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", name, act, want);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, want);
    end
  endtask

  // Loads the stream, pulses START and returns at the first cycle with the
  // gate asserted (cycle 0 of the lead-in).
  task automatic run_to_gate(input logic [7:0] b0, b1, b2, b3, input int d);
    repeat (3) @(negedge CLOCK);
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
    base = ack_count;
    mem_delay = d;
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    for (int i = 0; i < 300 && FD_WRGATE; i++) @(negedge CLOCK);
    chk1("gate_asserted", FD_WRGATE, 1'b0);
  endtask

  task automatic chk_idle(input string name);
    chk1({name, "_wrdata"}, FD_WRDATA, 1'b1);
    chk1({name, "_wrgate"}, FD_WRGATE, 1'b1);
    chk1({name, "_req"}, MEM_RD_REQ, 1'b0);
    chk1({name, "_busy"}, BUSY, 1'b0);
  endtask

  initial begin
    int first_low;
    logic bad;

    //          start abort wp   busy err gate req
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (2) @(negedge CLOCK);
    chk_idle("reset");
    chk1("reset_done", DONE, 1'b0);
    chk1("reset_underrun", UNDERRUN, 1'b0);
    chk1("reset_wprot", WRPROT_ERR, 1'b0);
    RESET = 1'b0;

    // Control pins: protect refusal, ABORT beating START, START ignored when busy.
    mem_delay = 1000;
    for (int i = 0; i < 8; i++) begin
      START = tbl[i].start;
      ABORT = tbl[i].abort;
      FD_WRPROT_IN = tbl[i].wp;
      @(negedge CLOCK);
      chk1($sformatf("vec%0d_busy", i), BUSY, tbl[i].busy);
      chk1($sformatf("vec%0d_wprot", i), WRPROT_ERR, tbl[i].err);
      chk1($sformatf("vec%0d_wrgate", i), FD_WRGATE, tbl[i].gate);
      chk1($sformatf("vec%0d_req", i), MEM_RD_REQ, tbl[i].req);
    end
    START = 1'b0; ABORT = 1'b0; FD_WRPROT_IN = 1'b1;

    // Basic stream {10,00,FF}: pulse low 24..31 (two merged 0x00-style
    // periods), gate released at 40.
    run_to_gate(8'h10, 8'h00, 8'hFF, 8'hFF, 0);
    chk1("basic_wprot_cleared", WRPROT_ERR, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLOCK);
      case (k)
        23: chk1("basic_k23_high", FD_WRDATA, 1'b1);
        24: chk1("basic_k24_pulse", FD_WRDATA, 1'b0);
        28: chk1("basic_k28_second", FD_WRDATA, 1'b0);
        31: chk1("basic_k31_low", FD_WRDATA, 1'b0);
        32: chk1("basic_k32_release", FD_WRDATA, 1'b1);
        39: begin
          chk1("basic_k39_gate", FD_WRGATE, 1'b0);
          chk1("basic_k39_done", DONE, 1'b0);
        end
        40: begin
          chk1("basic_k40_gate", FD_WRGATE, 1'b1);
          chk1("basic_k40_done", DONE, 1'b1);
          chk1("basic_k40_busy", BUSY, 1'b0);
        end
        default: ;
      endcase
    end

    // Index wait then gap: an index edge during lead-in is ignored.
    run_to_gate(8'hFE, 8'h80, 8'h05, 8'hFF, 0);
    chk1("idx_done_cleared", DONE, 1'b0);
    bad = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLOCK);
      if (k == 1) FD_INDEX_IN = 1'b0;
      if (k == 4) FD_INDEX_IN = 1'b1;
      if (FD_WRDATA !== 1'b1 || FD_WRGATE !== 1'b0) bad = 1'b1;
    end
    chk1("idx_no_pulse_before_index", bad, 1'b0);
    FD_INDEX_IN = 1'b0;
    first_low = -1;
    for (int k = 1; k <= 148; k++) begin
      @(negedge CLOCK);
      if (first_low < 0 && FD_WRDATA === 1'b0) first_low = k;
      if (k == 140) chk1("idx_pulse_end", FD_WRDATA, 1'b1);
      if (k == 147) chk1("idx_trail_gate", FD_WRGATE, 1'b0);
    end
    chk_int("idx_first_pulse_cycle", first_low, 136);
    chk1("idx_gate_released", FD_WRGATE, 1'b1);
    chk1("idx_done", DONE, 1'b1);
    FD_INDEX_IN = 1'b1;

    // Underrun: slow SRAM cannot refill before the first command ends at 13.
    run_to_gate(8'h02, 8'h02, 8'hFF, 8'hFF, 20);
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLOCK);
      case (k)
        9:  chk1("und_k9_high", FD_WRDATA, 1'b1);
        10: chk1("und_k10_pulse", FD_WRDATA, 1'b0);
        13: begin
          chk1("und_k13_gate", FD_WRGATE, 1'b0);
          chk1("und_k13_flag", UNDERRUN, 1'b0);
        end
        default: ;
      endcase
    end
    chk_idle("und_k14");
    chk1("und_flag", UNDERRUN, 1'b1);
    chk1("und_done", DONE, 1'b0);

    // Abort in the second PULSE cycle truncates the pulse.
    run_to_gate(8'h03, 8'h03, 8'hFF, 8'hFF, 0);
    chk1("abort_und_cleared", UNDERRUN, 1'b0);
    for (int k = 1; k <= 12; k++) @(negedge CLOCK);
    chk1("abort_in_pulse", FD_WRDATA, 1'b0);
    ABORT = 1'b1;
    @(negedge CLOCK);
    ABORT = 1'b0;
    chk_idle("abort");
    chk1("abort_done", DONE, 1'b0);
    chk1("abort_und", UNDERRUN, 1'b0);
    chk1("abort_wprot", WRPROT_ERR, 1'b0);

    // Reset during lead-in.
    run_to_gate(8'h10, 8'hFF, 8'hFF, 8'hFF, 0);
    repeat (3) @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    chk_idle("rst_lead");
    chk1("rst_lead_done", DONE, 1'b0);

    // START and ABORT together: block stays idle.
    repeat (2) @(negedge CLOCK);
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    ABORT = 1'b0;
    chk_idle("start_abort");
    repeat (5) @(negedge CLOCK);
    chk_idle("start_abort_later");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
